// File: rtl/handshake_pkg.sv
// Shared definitions for the 4-phase handshake arbiter: FSM state encoding
// and the default data word width.
package handshake_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_WAIT_ACK     = 2'd1,
        ST_WAIT_DROP    = 2'd2,
        ST_WAIT_RELEASE = 2'd3
    } state_t;

    localparam int DATA_W = 16;

endpackage

// File: rtl/handshake_arbiter_if.sv
// Bundle of the sender-side and receiver-side handshake signals of the arbiter.
// The slave modport is the arbiter's view; the master modport is the view of
// the surrounding senders/receiver.
interface handshake_arbiter_if
    import handshake_pkg::*;
#(
    parameter int N   = 4,
    parameter int W   = DATA_W,
    parameter int IDW = 2
);
    logic [N-1:0]   ReqIn;
    logic [N*W-1:0] DataIn;
    logic [N-1:0]   AckOut;
    logic           ReqOut;
    logic [W-1:0]   DataOut;
    logic           AckIn;
    logic [IDW-1:0] GrantId;
    logic           Busy;

    modport slave (
        input  ReqIn, DataIn, AckIn,
        output AckOut, ReqOut, DataOut, GrantId, Busy
    );

    modport master (
        output ReqIn, DataIn, AckIn,
        input  AckOut, ReqOut, DataOut, GrantId, Busy
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational winner selection: rotate the request vector so ptr sits at
// bit 0, take the lowest set bit, then rotate the index back.
// With HANDSHAKE_ARB_FIXED_PRIO_EN defined there is no ptr input and the
// lowest set request index wins directly.
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
`ifndef HANDSHAKE_ARB_FIXED_PRIO_EN
    input  logic [IDW-1:0] ptr,
`endif
    output logic           valid,
    output logic [IDW-1:0] idx
);

    assign valid = |req;

`ifdef HANDSHAKE_ARB_FIXED_PRIO_EN
    // Lowest index wins: scan downwards so the last hit is the smallest.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = IDW'(i);
        end
    end
`else
    localparam logic [IDW:0] NUM = (IDW + 1)'(N);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IDW:0]   ptr_ext;
    logic [IDW-1:0] rot_idx;
    logic [IDW:0]   sum;

    assign dbl     = {req, req};
    assign ptr_ext = {1'b0, ptr};

    // Doubled vector lets a plain offset select implement the cyclic rotate.
    for (genvar gi = 0; gi < N; gi++) begin : g_rot
        assign rot[gi] = dbl[ptr_ext + (IDW + 1)'(gi)];
    end

    // Priority-encode the rotated vector, then add ptr back modulo N.
    always_comb begin
        rot_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) rot_idx = IDW'(i);
        end
        sum = {1'b0, rot_idx} + ptr_ext;
        if (sum >= NUM) sum = sum - NUM;
        idx = sum[IDW-1:0];
    end
`endif

endmodule

// File: rtl/handshake_arbiter.sv
// N-to-1 arbiter for a 4-phase Request/Ack/Data channel. One requester is
// granted at a time, its word is latched, and the full downstream handshake
// runs before the channel is re-arbitrated (round-robin by default).
// Optional macro HANDSHAKE_ARB_FIXED_PRIO_EN: fixed priority, lowest index
// wins, and the rotating pointer is removed.
module handshake_arbiter
    import handshake_pkg::*;
#(
    parameter int N   = 4,
    parameter int W   = DATA_W,
    parameter int IDW = 2
) (
    input logic          clk,
    input logic          Reset,
    handshake_arbiter_if.slave bus
);

    state_t         state_q, state_d;
    logic           req_out_q, req_out_d;
    logic [N-1:0]   ack_out_q, ack_out_d;
    logic [W-1:0]   data_out_q, data_out_d;
    logic [IDW-1:0] grant_q, grant_d;

    logic           pick_valid;
    logic [IDW-1:0] pick_idx;
    logic [W-1:0]   slice [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_slice
        assign slice[gi] = bus.DataIn[gi*W +: W];
    end

`ifdef HANDSHAKE_ARB_FIXED_PRIO_EN
    rr_pick #(.N(N), .IDW(IDW)) u_pick (
        .req   (bus.ReqIn),
        .valid (pick_valid),
        .idx   (pick_idx)
    );
`else
    logic [IDW-1:0] ptr_q, ptr_d;

    rr_pick #(.N(N), .IDW(IDW)) u_pick (
        .req   (bus.ReqIn),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );
`endif

    // Next-state and next-output logic of the handshake FSM.
    always_comb begin
        state_d    = state_q;
        req_out_d  = req_out_q;
        ack_out_d  = ack_out_q;
        data_out_d = data_out_q;
        grant_d    = grant_q;
`ifndef HANDSHAKE_ARB_FIXED_PRIO_EN
        ptr_d      = ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d    = pick_idx;
                    data_out_d = slice[pick_idx];
                    req_out_d  = 1'b1;
                    state_d    = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (bus.AckIn) begin
                    ack_out_d = N'(1) << grant_q;
                    state_d   = ST_WAIT_DROP;
                end
            end
            ST_WAIT_DROP: begin
                if (!bus.ReqIn[grant_q]) begin
                    req_out_d = 1'b0;
                    state_d   = ST_WAIT_RELEASE;
                end
            end
            ST_WAIT_RELEASE: begin
                if (!bus.AckIn) begin
                    ack_out_d = '0;
`ifndef HANDSHAKE_ARB_FIXED_PRIO_EN
                    ptr_d = (grant_q == IDW'(N - 1)) ? '0 : grant_q + 1'b1;
`endif
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            req_out_q  <= 1'b0;
            ack_out_q  <= '0;
            data_out_q <= '0;
            grant_q    <= '0;
`ifndef HANDSHAKE_ARB_FIXED_PRIO_EN
            ptr_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            req_out_q  <= req_out_d;
            ack_out_q  <= ack_out_d;
            data_out_q <= data_out_d;
            grant_q    <= grant_d;
`ifndef HANDSHAKE_ARB_FIXED_PRIO_EN
            ptr_q      <= ptr_d;
`endif
        end
    end

    assign bus.ReqOut  = req_out_q;
    assign bus.AckOut  = ack_out_q;
    assign bus.DataOut = data_out_q;
    assign bus.GrantId = grant_q;
    assign bus.Busy    = (state_q != ST_IDLE);

endmodule
